// File: rtl/md_sequencer.sv
// Multiply/divide sequencer between EX and the shared iterative div_mul core.
// Optional MD_FAST_MUL_EN: multiplies complete in one cycle without the core.
module md_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  input  logic        flush,
  input  logic        hold,
  output logic        stallreq,
  output logic        busy,
  output logic        core_start,
  output logic        core_signed,
  output logic [1:0]  core_choose,
  output logic        core_annul,
  output logic [31:0] core_opdata1,
  output logic [31:0] core_opdata2,
  input  logic [63:0] core_result,
  input  logic        core_ready,
  output logic        hilo_we,
  output logic [31:0] hilo_hi,
  output logic [31:0] hilo_lo,
  output logic        md_err
);

  // state | meaning
  // IDLE  | waiting for an op from EX
  // RUN   | core iterating, pipeline stalled, watchdog counting
  // DONE  | result held, HI/LO written when hold is low
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] src1_q, src2_q;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;
  logic        accept;

`ifdef MD_FAST_MUL_EN
  logic        ext1, ext2;
  logic [63:0] mul_a, mul_b, mul_prod;

  // Low 64 bits of the sign-extended product equal the 33x33 signed product.
  assign ext1     = ~op_type[0] & op_src1[31];
  assign ext2     = ~op_type[0] & op_src2[31];
  assign mul_a    = {{32{ext1}}, op_src1};
  assign mul_b    = {{32{ext2}}, op_src2};
  assign mul_prod = mul_a * mul_b;
`endif

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    accept      = 1'b0;
    stallreq    = 1'b0;
    core_start  = 1'b0;
    core_signed = 1'b0;
    core_choose = 2'b00;
    core_annul  = 1'b0;
    hilo_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          stallreq = 1'b1;
          accept   = 1'b1;
          cnt_d    = 8'd0;
          if (op_type[1] && (op_src2 == 32'd0)) begin
            state_d = S_DONE;
            res_d   = {op_src1, 32'hFFFF_FFFF};
          end
`ifdef MD_FAST_MUL_EN
          else if (!op_type[1]) begin
            state_d = S_DONE;
            res_d   = mul_prod;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        stallreq    = 1'b1;
        core_signed = ~op_q[0];
        core_choose = op_q[1] ? 2'b01 : 2'b11;
        if (flush) begin
          core_annul = 1'b1;
          state_d    = S_IDLE;
        end else begin
          core_start = 1'b1;
          cnt_d      = cnt_inc;
          if (core_ready) begin
            res_d   = core_result;
            state_d = S_DONE;
          end else if (cnt_inc == TIMEOUT_CNT) begin
            core_annul = 1'b1;
            err_d      = 1'b1;
            res_d      = 64'd0;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Leaving DONE clears the result so HI/LO read 0 outside DONE.
        if (flush) begin
          state_d = S_IDLE;
          res_d   = 64'd0;
        end else if (!hold) begin
          hilo_we = 1'b1;
          state_d = S_IDLE;
          res_d   = 64'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      cnt_q   <= 8'd0;
      res_q   <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      if (accept) begin
        op_q   <= op_type;
        src1_q <= op_src1;
        src2_q <= op_src2;
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign core_opdata1 = src1_q;
  assign core_opdata2 = src2_q;
  assign hilo_hi      = res_q[63:32];
  assign hilo_lo      = res_q[31:0];
  assign md_err       = err_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer with a hand-driven core model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush, hold, core_ready;
  logic [1:0]  op_type;
  logic [31:0] op_src1, op_src2;
  logic [63:0] core_result;
  logic        stallreq, busy, core_start, core_signed, core_annul, hilo_we, md_err;
  logic [1:0]  core_choose;
  logic [31:0] core_opdata1, core_opdata2, hilo_hi, hilo_lo;

  int total = 0;
  int bad   = 0;

  md_sequencer #(.TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .op_src1(op_src1), .op_src2(op_src2), .flush(flush), .hold(hold),
    .stallreq(stallreq), .busy(busy), .core_start(core_start),
    .core_signed(core_signed), .core_choose(core_choose), .core_annul(core_annul),
    .core_opdata1(core_opdata1), .core_opdata2(core_opdata2),
    .core_result(core_result), .core_ready(core_ready),
    .hilo_we(hilo_we), .hilo_hi(hilo_hi), .hilo_lo(hilo_lo), .md_err(md_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; the core reports ready in RUN cycle k with result res.
  task automatic do_op(input string tag, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b, input int k, input logic [63:0] res,
                       input int exp_stall, input int exp_starts,
                       input logic exp_sgn, input logic [1:0] exp_choose);
    int stall_n = 0, start_n = 0;
    logic got = 1'b0, sgn_seen = 1'b0;
    logic [1:0] choose_seen = 2'b00;
    tick();
    op_valid = 1'b1; op_type = t; op_src1 = a; op_src2 = b;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (hilo_we) begin
        got = 1'b1;
        break;
      end
      if (stallreq) stall_n++;
      if (core_start) begin
        start_n++;
        if (start_n == 1) begin
          sgn_seen = core_signed;
          choose_seen = core_choose;
        end
        if (start_n == k) begin
          core_ready = 1'b1;
          core_result = res;
        end
      end
      tick();
      op_valid = 1'b0;
      core_ready = 1'b0;
    end
    chk({tag, "_we"}, 64'(got), 64'd1);
    chk({tag, "_stall_in_done"}, 64'(stallreq), 64'd0);
    chk({tag, "_hi"}, 64'(hilo_hi), 64'(res[63:32]));
    chk({tag, "_lo"}, 64'(hilo_lo), 64'(res[31:0]));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    chk({tag, "_starts"}, 64'(start_n), 64'(exp_starts));
    if (exp_starts > 0) begin
      chk({tag, "_signed"}, 64'(sgn_seen), 64'(exp_sgn));
      chk({tag, "_choose"}, 64'(choose_seen), 64'(exp_choose));
    end
    tick();
    #2;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_hi"}, 64'(hilo_hi), 64'd0);
    chk({tag, "_idle_we"}, 64'(hilo_we), 64'd0);
  endtask

  initial begin
    int run_n, annul_at, annul_n, we_n;
    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_src1 = 0; op_src2 = 0;
    flush = 1'b0; hold = 1'b0; core_ready = 1'b0; core_result = 64'd0;
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_hilo", {hilo_hi, hilo_lo}, 64'd0);
    chk("rst_err", 64'(md_err), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);

    // core_ready outside RUN is ignored
    tick(); core_ready = 1'b1; core_result = 64'hDEAD;
    tick(); core_ready = 1'b0;
    #2;
    chk("idle_ready_busy", 64'(busy), 64'd0);
    chk("idle_ready_hilo", {hilo_hi, hilo_lo}, 64'd0);

    do_op("divu", 2'b11, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 34, 33, 1'b0, 2'b01);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF7, 32'd2, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFC}, 6, 5, 1'b1, 2'b01);
    do_op("div0", 2'b10, 32'd5, 32'd0, 0, {32'd5, 32'hFFFF_FFFF}, 1, 0, 1'b1, 2'b01);
`ifdef MD_FAST_MUL_EN
    do_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd2, 3, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1, 0, 1'b1, 2'b11);
    do_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 3, {32'h0000_0001, 32'hFFFF_FFFE}, 1, 0, 1'b0, 2'b11);
`else
    do_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd2, 3, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 4, 3, 1'b1, 2'b11);
    do_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 3, {32'h0000_0001, 32'hFFFF_FFFE}, 4, 3, 1'b0, 2'b11);
`endif

    // flush in 5th RUN cycle, coinciding with core_ready
    tick(); op_valid = 1'b1; op_type = 2'b11; op_src1 = 32'd12; op_src2 = 32'd5;
    tick(); op_valid = 1'b0;
    #2;
    chk("fl_opdata1", 64'(core_opdata1), 64'd12);
    chk("fl_opdata2", 64'(core_opdata2), 64'd5);
    tick(); tick(); tick(); tick();
    flush = 1'b1; core_ready = 1'b1; core_result = {32'd2, 32'd2};
    #1;
    chk("fl_annul", 64'(core_annul), 64'd1);
    chk("fl_start", 64'(core_start), 64'd0);
    annul_n = 0; we_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); flush = 1'b0; core_ready = 1'b0;
      #2;
      if (core_annul) annul_n++;
      if (hilo_we) we_n++;
    end
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_annul_once", 64'(annul_n), 64'd0);
    chk("fl_no_we", 64'(we_n), 64'd0);
    do_op("post_flush", 2'b11, 32'd8, 32'd2, 4, {32'd0, 32'd4}, 5, 4, 1'b0, 2'b01);

    // hold for 3 DONE cycles
    tick(); op_valid = 1'b1; op_type = 2'b11; op_src1 = 32'd9; op_src2 = 32'd4; hold = 1'b1;
    tick(); op_valid = 1'b0;
    tick(); core_ready = 1'b1; core_result = {32'd1, 32'd2};
    #2;
    chk("hold_run_stall", 64'(stallreq), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); core_ready = 1'b0;
      #2;
      chk("hold_we", 64'(hilo_we), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_stall", 64'(stallreq), 64'd0);
      chk("hold_result", {hilo_hi, hilo_lo}, {32'd1, 32'd2});
    end
    hold = 1'b0;
    #1;
    chk("hold_release_we", 64'(hilo_we), 64'd1);
    tick(); #2;
    chk("hold_after_we", 64'(hilo_we), 64'd0);
    chk("hold_after_busy", 64'(busy), 64'd0);

    // watchdog: core never ready
    tick(); op_valid = 1'b1; op_type = 2'b11; op_src1 = 32'd1; op_src2 = 32'd1;
    tick(); op_valid = 1'b0;
    run_n = 0; annul_at = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (core_start) run_n++;
      if (core_annul) begin
        annul_at = run_n;
        break;
      end
      tick();
    end
    chk("wd_annul_cycle", 64'(annul_at), 64'd40);
    tick(); #2;
    chk("wd_we", 64'(hilo_we), 64'd1);
    chk("wd_hilo", {hilo_hi, hilo_lo}, 64'd0);
    chk("wd_err", 64'(md_err), 64'd1);
    do_op("post_wd", 2'b11, 32'd8, 32'd2, 2, {32'd0, 32'd4}, 3, 2, 1'b0, 2'b01);
    chk("wd_err_sticky", 64'(md_err), 64'd1);

    // reset mid-RUN
    tick(); op_valid = 1'b1; op_type = 2'b10; op_src1 = 32'd7; op_src2 = 32'd3;
    tick(); op_valid = 1'b0;
    tick(); rst = 1'b1;
    #1;
    chk("rstrun_annul", 64'(core_annul), 64'd0);
    tick(); rst = 1'b0;
    #2;
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_err", 64'(md_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
